// File: rtl/mod_counter_pkg.sv
// Shared types for the programmable-modulus counter: FSM state, direction
// encoding and the run configuration latched on start.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Direction and mode captured on start; modulus is shadowed separately
  // because its width is a module parameter.
  typedef struct packed {
    logic dir;
    logic oneshot;
  } shadow_t;

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter. The master drives controls and
// observes status; the counter itself uses the slave view.
interface mod_counter_if #(
  parameter int W  = 8,
  parameter int PW = 4
);
  logic          en;
  logic          clr;
  logic          start;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  modulus;
  logic          dir;
  logic          oneshot;
  logic [PW-1:0] prescale;
  logic [W-1:0]  Q;
  logic          carry;
  logic          busy;
  logic          done;

  modport master (
    output en, clr, start, load, load_val, modulus, dir, oneshot, prescale,
    input  Q, carry, busy, done
  );

  modport slave (
    input  en, clr, start, load, load_val, modulus, dir, oneshot, prescale,
    output Q, carry, busy, done
  );
endinterface

// File: rtl/mod_counter_prescale_tick.sv
// Prescale divider: emits one tick every prescale+1 enabled cycles.
// clr_pc wins over en so a restart always begins a fresh interval.
module prescale_tick #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr_pc,
  input  logic [PW-1:0] prescale,
  output logic          tick
);

  logic [PW-1:0] pc;

  assign tick = en && !clr_pc && (pc == prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc <= '0;
    else if (clr_pc)
      pc <= '0;
    else if (en)
      pc <= (pc == prescale) ? '0 : pc + PW'(1);
  end

endmodule

// File: rtl/mod_counter.sv
// Programmable-modulus up/down timer with prescaler, load and wrap/one-shot
// modes. The FSM, shadowed run configuration and count datapath live here.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 4
) (
  input logic          clk,
  input logic          rst,
  mod_counter_if.slave bus
);

  state_t       state_q, state_d;
  shadow_t      shd_q, shd_d;
  logic [W-1:0] mod_q, mod_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         carry_q, carry_d;
  logic         busy_q, done_q;
  logic         tick;
  logic         term;
  logic         tick_eff;
  logic [W-1:0] load_clamped;

  prescale_tick #(.PW(PW)) u_ptick (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en && (state_q == RUN)),
    .clr_pc   (bus.clr || bus.start),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  assign term         = (shd_q.dir == DIR_UP) ? (cnt_q == mod_q) : (cnt_q == '0);
  assign load_clamped = (bus.load_val > mod_q) ? mod_q : bus.load_val;
  // A tick in a clr/start/load cycle is overridden and must not move the count.
  assign tick_eff     = tick && !bus.clr && !bus.start && !bus.load;

  always_comb begin
    state_d = state_q;
    if (bus.clr)
      state_d = IDLE;
    else if (bus.start)
      state_d = RUN;
    else if (tick_eff && term && shd_q.oneshot)
      state_d = DONE;
  end

  always_comb begin
    shd_d   = shd_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.start) begin
      shd_d.dir     = bus.dir;
      shd_d.oneshot = bus.oneshot;
      mod_d         = bus.modulus;
      cnt_d         = (bus.dir == DIR_UP) ? '0 : bus.modulus;
    end else if (bus.load) begin
      cnt_d = load_clamped;
    end else if (tick_eff) begin
      if (term) begin
        carry_d = 1'b1;
        if (!shd_q.oneshot)
          cnt_d = (shd_q.dir == DIR_UP) ? '0 : mod_q;
      end else begin
        cnt_d = (shd_q.dir == DIR_UP) ? cnt_q + W'(1) : cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shd_q   <= '0;
      mod_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shd_q   <= shd_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.Q     = cnt_q;
  assign bus.carry = carry_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed and random stimulus for mod_counter, checked every cycle against
// an integer reference model of the counter's behaviour.
module tb_mod_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  // reference model state: 0 idle, 1 run, 2 done
  int m_q, m_pc, m_st, m_mod, m_dir, m_os, m_carry;

  always #5 clk = ~clk;

  mod_counter_if #(.W(W), .PW(PW)) bus ();

  mod_counter #(.W(W), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_pc = 0; m_st = 0; m_mod = 0; m_dir = 0; m_os = 0; m_carry = 0;
  endtask

  task automatic model_step();
    int tk;
    m_carry = 0;
    if (bus.clr) begin
      m_q = 0; m_pc = 0; m_st = 0;
    end else if (bus.start) begin
      m_mod = int'(bus.modulus); m_dir = int'(bus.dir); m_os = int'(bus.oneshot);
      m_pc  = 0; m_st = 1;
      m_q   = m_dir ? 0 : m_mod;
    end else begin
      tk = 0;
      if (m_st == 1 && bus.en) begin
        if (m_pc == int'(bus.prescale)) begin tk = 1; m_pc = 0; end
        else m_pc = (m_pc + 1) % (1 << PW);
      end
      if (bus.load) begin
        m_q = (int'(bus.load_val) > m_mod) ? m_mod : int'(bus.load_val);
      end else if (tk == 1) begin
        if ((m_dir == 1) ? (m_q == m_mod) : (m_q == 0)) begin
          m_carry = 1;
          if (m_os == 1) m_st = 2;
          else m_q = m_dir ? 0 : m_mod;
        end else begin
          m_q = (m_dir == 1) ? m_q + 1 : m_q - 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Q"},     32'(bus.Q),     32'(m_q));
    chk({tag, ".carry"}, 32'(bus.carry), 32'(m_carry));
    chk({tag, ".busy"},  32'(bus.busy),  32'(m_st == 1));
    chk({tag, ".done"},  32'(bus.done),  32'(m_st == 2));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic idle_inputs();
    bus.en = 1'b1; bus.clr = 1'b0; bus.start = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.modulus = '0; bus.dir = 1'b1; bus.oneshot = 1'b0;
    bus.prescale = '0;
  endtask

  task automatic do_start(input string tag, input int md, input bit d, input bit os, input int ps);
    bus.modulus = W'(md); bus.dir = d; bus.oneshot = os; bus.prescale = PW'(ps);
    bus.start = 1'b1;
    step(tag);
    bus.start = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    run("post_reset", 2);

    // wrap up-count, modulus 5
    do_start("wrap_start", 5, 1'b1, 1'b0, 0);
    chk("wrap_q0", 32'(bus.Q), 32'd0);
    run("wrap_up", 5);
    chk("wrap_q5", 32'(bus.Q), 32'd5);
    step("wrap_edge");
    chk("wrap_carry", 32'(bus.carry), 32'd1);
    chk("wrap_back0", 32'(bus.Q), 32'd0);
    run("wrap_up2", 12);

    // down one-shot, prescale 2
    do_start("os_start", 3, 1'b0, 1'b1, 2);
    chk("os_q3", 32'(bus.Q), 32'd3);
    run("os_down", 12);
    chk("os_done", 32'(bus.done), 32'd1);
    chk("os_busy", 32'(bus.busy), 32'd0);
    run("os_hold", 5);
    chk("os_q_held", 32'(bus.Q), 32'd0);

    // load clamp and start-over-load priority
    do_start("ld_start", 10, 1'b1, 1'b0, 0);
    run("ld_run", 2);
    bus.load = 1'b1; bus.load_val = 8'd200;
    step("ld_clamp");
    chk("ld_clamp_q", 32'(bus.Q), 32'd10);
    bus.load_val = 8'd7;
    step("ld_plain");
    bus.start = 1'b1;
    step("ld_vs_start");
    chk("start_wins", 32'(bus.Q), 32'd0);
    bus.start = 1'b0; bus.load = 1'b0;
    run("ld_after", 3);

    // modulus change mid-run only applies after restart
    do_start("mc_start", 5, 1'b1, 1'b0, 0);
    run("mc_a", 2);
    bus.modulus = 8'd2;
    run("mc_b", 10);
    do_start("mc_restart", 2, 1'b1, 1'b0, 0);
    run("mc_c", 8);

    // en freeze then clr
    do_start("en_start", 5, 1'b1, 1'b0, 0);
    run("en_run", 3);
    chk("en_q3", 32'(bus.Q), 32'd3);
    bus.en = 1'b0;
    run("en_frozen", 4);
    chk("en_hold", 32'(bus.Q), 32'd3);
    bus.en = 1'b1; bus.clr = 1'b1;
    step("clr");
    bus.clr = 1'b0;
    chk("clr_busy", 32'(bus.busy), 32'd0);
    run("clr_idle", 5);
    chk("clr_noticks", 32'(bus.Q), 32'd0);

    // asynchronous reset between edges
    do_start("ar_start", 9, 1'b1, 1'b0, 0);
    run("ar_run", 4);
    chk("ar_q4", 32'(bus.Q), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    run("ar_after", 4);

    // random soak
    for (int i = 0; i < 1500; i++) begin
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.clr      = ($urandom_range(0, 59) == 0);
      bus.start    = ($urandom_range(0, 24) == 0);
      bus.load     = ($urandom_range(0, 19) == 0);
      bus.load_val = W'($urandom_range(0, 255));
      bus.modulus  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                 : W'($urandom_range(0, 12));
      bus.dir      = 1'($urandom_range(0, 1));
      bus.oneshot  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) bus.prescale = PW'($urandom_range(0, 3));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised programmable-modulus timer/counter, the next generation of the basic free-running counter. It adds up/down direction, a run-time modulus, a prescaler, a synchronous load, and wrap or one-shot modes. A controlling FSM drives busy/done status. It serves as the general tick/interval generator for WimpFi, e.g. baud-rate ticks, bit-period timing and timeout watchdogs.

Parameters:
W, 8, width of count value, modulus and load value
PW, 4, width of prescale divider value

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  global enable; low freezes prescaler and Q
clr  in  1  synchronous clear to idle
start  in  1  begin or restart a count run
load  in  1  synchronous load of Q from load_val
load_val  in  W  value for load
modulus  in  W  terminal value; count range 0..modulus
dir  in  1  1 = count up, 0 = count down
oneshot  in  1  0 = wrap mode, 1 = one-shot mode
prescale  in  PW  tick every prescale+1 enabled RUN cycles
Q  out  W  current count
carry  out  1  one-cycle terminal-count pulse, registered
busy  out  1  high in RUN
done  out  1  high in DONE (one-shot complete)

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-run): Q=0, carry=0, busy=0, done=0, prescale count pc=0, state IDLE, shadow regs = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE --start--> RUN.
  - RUN --start--> RUN (restart).
  - RUN --terminal tick with oneshot=1--> DONE.
  - any --clr--> IDLE.
- start is accepted regardless of en. It has these effects:
  - samples modulus, dir and oneshot into shadow registers; mid-run changes take no effect until the next start.
  - sets pc=0.
  - sets Q=0 for up, or Q=modulus for down.
- Per-cycle priority: clr > start > load > tick.
- load (any state) sets Q to load_val, clamped to the shadow modulus if load_val > shadow modulus. It does not change state or pc.
- Tick generation applies only in RUN with en=1:
  - if pc==prescale: tick=1 and pc=0.
  - otherwise pc increments.
  - prescale=0 gives a tick every enabled cycle.
- Terminal condition is Q==mod_s when counting up, Q==0 when counting down.
- Tick when not at terminal: Q moves by ±1.
- Tick at terminal, wrap mode: Q reloads (up: 0, down: mod_s) and carry=1 in the next cycle.
- Tick at terminal, one-shot mode: Q holds, carry=1 in the next cycle, state goes to DONE.
- carry is high for exactly one cycle per terminal tick. It is registered and coincides with Q already wrapped or held.
- mod_s=0: every tick is terminal. In wrap mode Q stays 0 and carry fires on every tick.
- Q never exceeds mod_s; arithmetic is modulo 2^W, with no overflow path.
- en=0 in RUN: Q, pc and state hold, and carry stays 0.
- clr: Q=0, pc=0, carry=0, done=0, busy=0, state IDLE.
- busy and done are registered decodes of the state.

Decomposition:
- Package mod_counter_pkg holds state_t enum {IDLE, RUN, DONE} and the localparam for the up/down encodings.
- One sub-module, prescale_tick (PW param), takes clk, rst, en, clr_pc, prescale and outputs tick.
- The FSM, shadow registers and count datapath live in mod_counter.

Test Plan:
- Wrap up-count: W=8, modulus=5, dir=1, prescale=0, start, en=1 -> Q: 0,1,2,3,4,5,0,...; carry high exactly in the cycle Q returns to 0, every 6 cycles; busy=1.
- Down one-shot with prescale: modulus=3, dir=0, oneshot=1, prescale=2 -> Q 3,2,1,0, each held for 3 cycles. At Q=0 the terminal tick gives one carry pulse, done=1, busy=0, and Q stays 0 until the next start.
- Load clamp and priority: in RUN with mod_s=10, load=1, load_val=200 -> Q=10. With start and load in the same cycle, start wins: Q=0 for up.
- Modulus change mid-run: modulus changed 5->2 during RUN -> wrap still at 5. After a restart via start, wrap at 2.
- en freeze and clr: en=0 for 4 cycles at Q=3 -> Q stays 3 and carry=0. Then clr -> Q=0, IDLE, busy=0, and no ticks until start.
- Async reset mid-run: drive rst=0 between clock edges while Q=4 -> all outputs go to 0 immediately, without waiting for a clock edge. After release, state is IDLE.
